// File: rtl/serial_negate_ctrl.sv
// Word-level negator built around the bit-serial two's-complement stage.
// It clears the stage, shifts the operand in LSB-first and collects the returned bits.
module serial_negate_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ovf,
    output logic             ser_i,
    output logic             ser_r,
    input  logic             ser_y
);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             ovf_pend;
    logic             load, shift;

    // The one operand whose negation does not fit: 1 followed by zeros.
    function automatic logic is_most_neg(input logic [WIDTH-1:0] v);
        return v == {1'b1, {(WIDTH-1){1'b0}}};
    endfunction

    assign ser_i   = op_sr[0];
    assign res_nxt = {ser_y, res_sr};

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: state_nxt = SHIFT;
            SHIFT: begin
                shift = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CLEAR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ser_r    <= 1'b1;
            dout     <= '0;
            ovf      <= 1'b0;
            ovf_pend <= 1'b0;
            cnt      <= '0;
            op_sr    <= '0;
            res_sr   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == CLEAR) || (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
            ser_r <= (state_nxt == CLEAR);

            if (load) begin
                op_sr    <= din;
                ovf_pend <= is_most_neg(din);
            end

            if (state == CLEAR) cnt <= '0;

            if (shift) begin
                op_sr  <= op_sr >> 1;
                res_sr <= res_nxt[WIDTH-1:1];
                cnt    <= cnt + 1'b1;
                if (cnt == LAST) begin
                    dout <= res_nxt;
                    ovf  <= ovf_pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed and random bench for serial_negate_ctrl, including a model of the serial stage.
module tb_serial_negate_ctrl;

    localparam int WIDTH = 8;

    logic             t_clk = 1'b0;
    logic             r;
    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy, done, ovf, ser_i, ser_r, ser_y;
    logic [WIDTH-1:0] dout;

    logic found = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   accepted = 0;

    serial_negate_ctrl #(.WIDTH(WIDTH), .CW(6)) dut (
        .t_clk (t_clk),
        .r     (r),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .ovf   (ovf),
        .ser_i (ser_i),
        .ser_r (ser_r),
        .ser_y (ser_y)
    );

    always #5 t_clk = ~t_clk;

    // Serial two's-complement stage: pass bits until the first 1, invert afterwards.
    always @(posedge t_clk or posedge ser_r) begin
        if (ser_r) found <= 1'b0;
        else if (ser_i) found <= 1'b1;
    end
    assign ser_y = ser_i ^ found;

    always @(negedge t_clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_word(input string tag, input logic [7:0] v,
                           input logic [7:0] exp_d, input logic exp_o, input bit full);
        int n;
        logic [7:0] seq;
        seq = '0;
        start = 1'b1;
        din   = v;
        @(negedge t_clk);
        start = 1'b0;
        din   = ~v;
        accepted++;
        if (full) begin
            check({tag, "_clr_ser_r"}, 32'(ser_r), 32'd1);
            check({tag, "_clr_busy"}, 32'(busy), 32'd1);
        end
        n = 1;
        while (!done && n < 20) begin
            @(negedge t_clk);
            n++;
            if (n >= 2 && n <= 9) seq[n-2] = ser_i;
        end
        check({tag, "_latency"}, 32'(n), 32'd10);
        check({tag, "_dout"}, 32'(dout), 32'(exp_d));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
        if (full) begin
            check({tag, "_ser_seq"}, 32'(seq), 32'(v));
            @(negedge t_clk);
            check({tag, "_done_single"}, 32'(done), 32'd0);
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
            check({tag, "_hold_dout"}, 32'(dout), 32'(exp_d));
        end
    endtask

    initial begin
        int n;
        logic [7:0] v;
        logic [7:0] e;
        int base_cnt;

        // Reset
        r = 1'b1;
        start = 1'b0;
        din = '0;
        @(negedge t_clk);
        check("rst_ser_r", 32'(ser_r), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge t_clk);
        r = 1'b0;
        @(negedge t_clk);
        check("rel_ser_r", 32'(ser_r), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_done", 32'(done), 32'd0);
        check("rel_ser_i", 32'(ser_i), 32'd0);

        // Directed words
        do_word("d01", 8'h01, 8'hFF, 1'b0, 1'b1);
        do_word("d7f", 8'h7F, 8'h81, 1'b0, 1'b1);
        do_word("d00", 8'h00, 8'h00, 1'b0, 1'b1);
        do_word("d80", 8'h80, 8'h80, 1'b1, 1'b1);
        do_word("dfe", 8'hFE, 8'h02, 1'b0, 1'b1);

        // Back-to-back with start held high
        start = 1'b1;
        din = 8'h05;
        n = 0;
        do begin
            @(negedge t_clk);
            n++;
        end while (!done && n < 20);
        accepted++;
        check("b2b_lat1", 32'(n), 32'd10);
        check("b2b_dout1", 32'(dout), 32'hFB);
        din = 8'h0C;
        n = 0;
        do begin
            @(negedge t_clk);
            n++;
        end while (!done && n < 20);
        accepted++;
        start = 1'b0;
        check("b2b_gap", 32'(n), 32'd10);
        check("b2b_dout2", 32'(dout), 32'hF4);
        check("b2b_ovf2", 32'(ovf), 32'd0);
        @(negedge t_clk);
        check("b2b_stop_busy", 32'(busy), 32'd0);

        // A start pulse during SHIFT is ignored and not queued
        start = 1'b1;
        din = 8'h33;
        @(negedge t_clk);
        start = 1'b0;
        accepted++;
        repeat (3) @(negedge t_clk);
        start = 1'b1;
        din = 8'h01;
        @(negedge t_clk);
        start = 1'b0;
        n = 5;
        while (!done && n < 20) begin
            @(negedge t_clk);
            n++;
        end
        check("ign_latency", 32'(n), 32'd10);
        check("ign_dout", 32'(dout), 32'hCD);
        repeat (3) @(negedge t_clk);
        check("ign_no_queue", 32'(busy), 32'd0);

        // Reset in the middle of SHIFT
        base_cnt = done_cnt;
        start = 1'b1;
        din = 8'h3C;
        @(negedge t_clk);
        start = 1'b0;
        repeat (4) @(negedge t_clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        r = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_dout", 32'(dout), 32'd0);
        check("mid_ser_r", 32'(ser_r), 32'd1);
        @(negedge t_clk);
        r = 1'b0;
        repeat (12) @(negedge t_clk);
        check("mid_no_done", 32'(done_cnt), 32'(base_cnt));
        do_word("post_rst", 8'h01, 8'hFF, 1'b0, 1'b1);

        // Random regression
        for (int i = 0; i < 200; i++) begin
            v = 8'($urandom_range(0, 255));
            e = -v;
            do_word("rnd", v, e, (v == 8'h80), 1'b0);
        end
        repeat (3) @(negedge t_clk);
        check("done_count", 32'(done_cnt), 32'(accepted));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_negate_ctrl.md
Name: serial_negate_ctrl

Overview:
Sequencer that wraps the bit-serial two's-complement stage (the `invert` cell: ports `i`, `r`, `t_clk`, `y`) so the stage can be used as a word-level negator.
- Accepts a parallel word on a start pulse.
- Clears the serial stage, then shifts the word in LSB-first, one bit per clock.
- Captures the returned serial bits into a parallel result and flags completion.
- Sits between the register file/ALU front end and the serial stage.

Parameters:
WIDTH, 8, data word width in bits (legal range 2..32)
CW, 6, width of the internal bit counter; must satisfy 2^CW > WIDTH

Ports:
t_clk  input  1  system clock, rising-edge active
r  input  1  reset, asynchronous, active-high
start  input  1  request to negate din; sampled on rising t_clk
din  input  WIDTH  operand, two's complement
busy  output  1  high while a conversion is in progress (CLEAR or SHIFT)
done  output  1  one-cycle pulse; dout and ovf are valid from this cycle on
dout  output  WIDTH  negated result (-din mod 2^WIDTH); holds until the next done
ovf  output  1  high when din = most-negative value (1 followed by WIDTH-1 zeros); holds with dout
ser_i  output  1  serial bit to the stage's `i`
ser_r  output  1  clear to the stage's `r`
ser_y  input  1  serial result from the stage's `y`

Behaviour:
- One clock (t_clk). Reset r is asynchronous and active-high.
- While r=1: state=IDLE, busy=0, done=0, dout=0, ovf=0, ser_i=0, ser_r=1, counter=0, shift register=0.
- Serial stage model the controller relies on:
  - ser_y = ser_i XOR found (combinational).
  - found is set on a t_clk edge when ser_i=1.
  - found is cleared while ser_r=1.
- States: IDLE, CLEAR, SHIFT, DONE. All outputs are registered, except ser_i, which is the LSB of the operand shift register.
- IDLE:
  - busy=0, ser_r=0.
  - On start=1: load din into the operand shift register, latch ovf_next = (din == {1,0...0}), go to CLEAR.
- CLEAR: exactly 1 cycle.
  - ser_r=1, busy=1, counter<=0.
  - Next state: SHIFT.
- SHIFT: exactly WIDTH cycles.
  - ser_r=0, busy=1.
  - Each cycle: ser_i = operand[0]; at the edge, result shift register <= {ser_y, result[WIDTH-1:1]}, operand >>= 1, counter++.
  - When counter = WIDTH-1 at the edge: go to DONE.
- DONE: exactly 1 cycle.
  - done=1, busy=0.
  - dout = result register; ovf = latched ovf_next.
  - dout/ovf are updated at the edge entering DONE and then held.
  - start=1 in this cycle is accepted (load din, go to CLEAR), giving back-to-back operation. Otherwise go to IDLE.
- Latency: start sampled at edge N → done high in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles after acceptance. Throughput: one word per WIDTH+2 cycles.
- start while busy=1 (CLEAR or SHIFT) is ignored: no queueing, and din is not re-sampled.
- din is only sampled on acceptance; changes after that have no effect on the result.
- Arithmetic:
  - dout = (~din + 1) mod 2^WIDTH.
  - din=0 → dout=0, ovf=0.
  - din=most-negative → dout=din, ovf=1.
- Reset mid-operation (any state): abort immediately and asynchronously.
  - All outputs return to their reset values; dout is cleared.
  - No done pulse is issued for the aborted word.
  - ser_r=1 during reset guarantees the stage is cleared.
- done is never asserted for two consecutive cycles.

Test Plan:
- r=1 for 2 cycles, then release with start=0 → busy=0, done=0, dout=0, ovf=0, ser_r=0 after release; ser_r=1 during reset.
- WIDTH=8, start with din=8'h01 → ser_r high 1 cycle, ser_i sequence 1,0,0,0,0,0,0,0; done pulses 10 cycles after acceptance with dout=8'hFF, ovf=0. Repeat for din=8'h7F → 8'h81, and din=8'h00 → 8'h00.
- din=8'h80 → dout=8'h80, ovf=1. Follow with din=8'hFE → dout=8'h02, ovf=0 (ovf clears).
- Back-to-back: start held high continuously with din=8'h05 then 8'h0C (changed in the DONE cycle) → done pulses exactly 10 cycles apart, dout=8'hFB then 8'hF4. Extra start pulses during SHIFT are ignored.
- Reset mid-SHIFT: start with din=8'h3C, assert r for 1 cycle after 4 shift cycles → busy and dout drop to 0 at once, no done pulse. A new start with din=8'h01 afterwards → dout=8'hFF (stage correctly cleared).
- Random regression: 200 random din values → every dout equals (-din) mod 256, ovf high only for 8'h80, and done count equals the number of accepted starts.
